// File: rtl/seg_display_mux.sv
// seg_display_mux: scans four BCD digits onto a multiplexed 7-segment display,
// with per-frame digit snapshots, a blinking adjust indication and a min/sec separator dot.
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_one,
  input  logic [3:0] sec_ten,
  input  logic [3:0] min_one,
  input  logic [3:0] min_ten,
  input  logic       blink_sec,
  input  logic       blink_min,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       digit_tick
);
  localparam int RW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = BLINK_DIV > 2 ? $clog2(BLINK_DIV) : 1;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d, tick_q, tick_d;
  logic          r_tc, b_tc, blank;
  logic [3:0]    digit;
  always_comb begin
    r_tc     = rcnt_q == RW'(REFRESH_DIV - 1);
    b_tc     = bcnt_q == BW'(BLINK_DIV - 1);
    rcnt_d   = r_tc ? '0 : rcnt_q + 1'b1;
    bcnt_d   = b_tc ? '0 : bcnt_q + 1'b1;
    idx_d    = r_tc ? idx_q + 2'd1 : idx_q;
    phase_d  = phase_q ^ b_tc;
    // Snapshot only at the frame boundary so one frame never mixes old and new digits
    shadow_d = (r_tc && idx_q == 2'd3) ? {min_ten, min_one, sec_ten, sec_one} : shadow_q;
    digit    = shadow_q[{idx_q, 2'b00} +: 4];
    blank    = phase_q && (idx_q[1] ? blink_min : blink_sec);
    an_d     = blank ? 4'hF : ~(4'b0001 << idx_q);
    dp_d     = !(idx_q == 2'd2 && !phase_q);
    tick_d   = r_tc;
    seg_d    = 7'b1111111;
    case (digit)
      4'd0: seg_d = 7'b1000000;
      4'd1: seg_d = 7'b1111001;
      4'd2: seg_d = 7'b0100100;
      4'd3: seg_d = 7'b0110000;
      4'd4: seg_d = 7'b0011001;
      4'd5: seg_d = 7'b0010010;
      4'd6: seg_d = 7'b0000010;
      4'd7: seg_d = 7'b1111000;
      4'd8: seg_d = 7'b0000000;
      4'd9: seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q   <= '0;
      bcnt_q   <= '0;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      shadow_q <= '0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      bcnt_q   <= bcnt_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_tick = tick_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed and randomized checks of the display scanner against
// a reference model driven by the number of cycles elapsed since reset.
module tb_seg_display_mux;
  localparam int R = 4;
  localparam int B = 64;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] sec_one, sec_ten, min_one, min_ten;
  logic blink_sec, blink_min;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, digit_tick;
  int checks = 0;
  int failures = 0;
  int t = 0;
  logic [3:0] sh [4];
  logic [6:0] lut [16];
  seg_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset),
    .sec_one(sec_one), .sec_ten(sec_ten), .min_one(min_one), .min_ten(min_ten),
    .blink_sec(blink_sec), .blink_min(blink_min),
    .an(an), .seg(seg), .dp(dp), .digit_tick(digit_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: predict from elapsed-cycle count t, clock it, compare, advance the model
  task automatic cyc();
    logic [3:0] ean;
    logic [6:0] eseg;
    logic edp, etk, bl;
    int idx, ph;
    if (reset) begin
      ean = 4'hF; eseg = 7'h7F; edp = 1'b1; etk = 1'b0; bl = 1'b0;
    end else begin
      idx  = (t / R) % 4;
      ph   = (t / B) % 2;
      bl   = (ph == 1) && (idx >= 2 ? blink_min : blink_sec);
      ean  = bl ? 4'hF : ~(4'b0001 << idx);
      eseg = lut[sh[idx]];
      edp  = !(idx == 2 && ph == 0);
      etk  = (t % R) == R - 1;
    end
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(ean));
    if (!bl) chk("seg", 32'(seg), 32'(eseg));
    chk("dp", 32'(dp), 32'(edp));
    chk("tick", 32'(digit_tick), 32'(etk));
    if (reset) begin
      t = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'd0;
    end else begin
      if (t % (4 * R) == 4 * R - 1) begin
        sh[0] = sec_one; sh[1] = sec_ten; sh[2] = min_one; sh[3] = min_ten;
      end
      t++;
    end
  endtask
  initial begin
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    int pulses, last, bound;
    for (int i = 0; i < 16; i++) lut[i] = 7'h7F;
    lut[0] = 7'b1000000; lut[1] = 7'b1111001; lut[2] = 7'b0100100; lut[3] = 7'b0110000;
    lut[4] = 7'b0011001; lut[5] = 7'b0010010; lut[6] = 7'b0000010; lut[7] = 7'b1111000;
    lut[8] = 7'b0000000; lut[9] = 7'b0010000;
    for (int i = 0; i < 4; i++) sh[i] = 4'd0;
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_seg[0] = 7'b0010000; exp_seg[1] = 7'b0010010; exp_seg[2] = 7'b0100100; exp_seg[3] = 7'b0110000;
    reset = 1'b1;
    {sec_one, sec_ten, min_one, min_ten} = '0;
    {blink_sec, blink_min} = 2'b00;
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    cyc();
    chk("rel_an", 32'(an), 32'b1110);
    chk("rel_seg", 32'(seg), 32'b1000000);
    repeat (3) cyc();
    chk("rel_tick", 32'(digit_tick), 32'd1);
    // Change digits mid-frame; they must only appear after the 3->0 wrap
    min_ten = 4'd3; min_one = 4'd2; sec_ten = 4'd5; sec_one = 4'd9;
    cyc();
    chk("old_seg", 32'(seg), 32'b1000000);
    while (t != 16) cyc();
    for (int d = 0; d < 4; d++) begin
      cyc();
      chk("snap_an", 32'(an), 32'(exp_an[d]));
      chk("snap_seg", 32'(seg), 32'(exp_seg[d]));
      chk("snap_dp", 32'(dp), d == 2 ? 32'd0 : 32'd1);
      repeat (R - 1) cyc();
    end
    sec_one = 4'd12;
    while (t != 48) cyc();
    cyc();
    chk("bad_an", 32'(an), 32'b1110);
    chk("bad_seg", 32'(seg), 32'h7F);
    blink_sec = 1'b1;
    repeat (160) cyc();
    blink_sec = 1'b0;
    for (int n = 0; n < 500; n++) begin
      {min_ten, min_one, sec_ten, sec_one} = 16'($urandom);
      if ($urandom_range(15) == 0) {blink_min, blink_sec} = 2'($urandom);
      reset = ($urandom_range(199) == 0);
      cyc();
    end
    reset = 1'b0;
    {blink_min, blink_sec} = 2'b00;
    bound = 0;
    while (t % (4 * R) != 2 * R && bound < 100) begin cyc(); bound++; end
    chk("idx2_found", 32'(t % (4 * R)), 32'(2 * R));
    reset = 1'b1;
    cyc();
    chk("mid_rst_an", 32'(an), 32'hF);
    reset = 1'b0;
    cyc();
    chk("mid_an", 32'(an), 32'b1110);
    chk("mid_seg", 32'(seg), 32'b1000000);
    chk("mid_dp", 32'(dp), 32'd1);
    pulses = 0;
    last = -1;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (digit_tick) begin
        if (last >= 0) chk("tick_gap", 32'(n - last), 32'(R));
        last = n;
        pulses++;
      end
    end
    chk("tick_count", 32'(pulses), 32'd10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is displayed; legal range is 2 or more.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink half-period; legal range is 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports sec_one, sec_ten, min_one, min_ten, each input, 4 bits: BCD time digits from the clock counter.
REQ-006 SHALL have ports blink_sec and blink_min, each input, 1 bit: blink the seconds or minutes digit pair (adjust-mode indication).
REQ-007 SHALL have port an, output, 4 bits: active-low digit enables; an[0]=sec_one, an[1]=sec_ten, an[2]=min_one, an[3]=min_ten.
REQ-008 SHALL have port seg, output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp, output, 1 bit: active-low decimal point, used as the min/sec separator.
REQ-010 SHALL have port digit_tick, output, 1 bit: one-cycle pulse on each scan advance.

Function
REQ-011 SHALL keep a refresh counter that runs 0..REFRESH_DIV-1 and wraps; the wrap cycle is the terminal count.
REQ-012 SHALL keep a 2-bit scan index that advances 0->1->2->3->0 on each refresh terminal count.
REQ-013 SHALL assert digit_tick for exactly the cycle in which the scan index advances, so pulses are REFRESH_DIV cycles apart.
REQ-014 SHALL load all four input digits into a shadow register only on the cycle the scan index wraps 3->0, so a frame never mixes old and new digits.
REQ-015 SHALL register an, seg and dp from the current-cycle scan index, shadow, blink phase and blink inputs, giving one cycle of latency behind the scan index.
REQ-016 SHALL drive exactly one an bit low, the one for the current index, unless that digit is blanked under REQ-019; in that case all an bits are high.
REQ-017 SHALL decode digits 0..9 to seg as follows:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-018 SHALL drive seg=1111111 (blank) for digit values 10..15.
REQ-019 SHALL keep a blink counter 0..BLINK_DIV-1 and toggle blink_phase at its terminal count.
- When blink_phase=1 and blink_sec=1, indices 0 and 1 are blanked.
- When blink_phase=1 and blink_min=1, indices 2 and 3 are blanked.
REQ-020 SHALL drive dp low only when the scan index is 2 and blink_phase=0; otherwise dp is high.
REQ-021 SHALL leave the refresh counter, scan index and blink counter running regardless of blink inputs or digit values.
REQ-022 SHALL apply blink_sec and blink_min without latching, so a change takes effect on the next output register update.

Reset
REQ-023 SHALL, with reset=1 at a clock edge, clear the refresh counter, scan index, blink counter, blink_phase and shadow digits to 0.
REQ-024 SHALL, with reset=1 at a clock edge, drive an=1111, seg=1111111, dp=1 and digit_tick=0.
REQ-025 SHALL, on the first edge with reset=0, output index 0 from shadow: an=1110 and seg=1000000. The first frame after reset always shows 00:00.
REQ-026 SHALL treat reset asserted mid-frame identically to reset from power-up; scanning restarts at index 0 with a full REFRESH_DIV dwell.

Verification (REFRESH_DIV=4, BLINK_DIV=64)
REQ-027 SHALL check reset: reset held 3 cycles -> an=1111, seg=1111111, dp=1; on release the next output is an=1110, seg=1000000, and the index-1 digit_tick occurs 4 cycles later.
REQ-028 SHALL check frame snapshot: inputs min_ten=3, min_one=2, sec_ten=5, sec_one=9 applied at index 1 -> the current frame still shows 0; after the 3->0 wrap it shows an=1110/seg=0010000, then an=1101/seg=0010010, an=1011/seg=0100100 with dp=0 in phase 0, and an=0111/seg=0110000.
REQ-029 SHALL check invalid BCD: sec_one=12 loaded -> index 0 shows an=1110, seg=1111111.
REQ-030 SHALL check blink: blink_sec=1 -> while blink_phase=1, indices 0 and 1 give an=1111 and indices 2 and 3 are unaffected; while blink_phase=0 all digits are shown and dp=0 at index 2.
REQ-031 SHALL check reset mid-operation: reset pulsed 1 cycle while index=2 -> the next cycle gives reset outputs, followed by an=1110 with shadow 0 and dp=1.
REQ-032 SHALL check digit_tick spacing: 40 free-running cycles -> exactly 10 pulses, each exactly 4 cycles apart.
